// File: rtl/note_highway_if.sv
// Bus bundle for note_highway: song/strum inputs toward the highway and
// highway/judging results back toward display and scoring.
interface note_highway_if #(
    parameter int DEPTH = 16
);
    logic                 beat;
    logic [4:0]           note_in;
    logic                 strum;
    logic [4:0]           frets;
    logic [5*DEPTH-1:0]   highway;
    logic                 hit;
    logic                 miss;
    logic [15:0]          score;
    logic [7:0]           streak;
    logic [2:0]           mult;

    modport master (
        output beat, note_in, strum, frets,
        input  highway, hit, miss, score, streak, mult
    );

    modport slave (
        input  beat, note_in, strum, frets,
        output highway, hit, miss, score, streak, mult
    );
endinterface

// File: rtl/note_highway.sv
// note_highway: scrolling five-lane note highway with strum judging,
// streak and saturating score. Row 0 is the hit zone.
// Optional feature: NOTE_HIGHWAY_STREAK_MULT_EN enables a streak-based
// score multiplier (1..4); without it the multiplier is fixed at 1.
module note_highway #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    note_highway_if.slave bus
);
    logic [4:0]         row_q [DEPTH];
    logic [4:0]         row_d [DEPTH];
    logic               judged_q, judged_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [15:0]        score_q, score_d;
    logic [7:0]         streak_q, streak_d;
    logic [2:0]         mult_w;
    logic [5*DEPTH-1:0] highway_w;
    logic [4:0]         zone;
    logic               strum_hit;
    logic               overstrum;
    logic               note_missed;
    logic [16:0]        score_sum;

    assign zone = row_q[0];

    // Multiplier derived from the registered streak, i.e. the pre-hit value
`ifdef NOTE_HIGHWAY_STREAK_MULT_EN
    always_comb begin
        if (streak_q >= 8'd30)      mult_w = 3'd4;
        else if (streak_q >= 8'd20) mult_w = 3'd3;
        else if (streak_q >= 8'd10) mult_w = 3'd2;
        else                        mult_w = 3'd1;
    end
`else
    always_comb begin
        mult_w = 3'd1;
    end
`endif

    // Judge the strum against the pre-shift zone and compute next state
    always_comb begin
        row_d       = row_q;
        judged_d    = judged_q;
        score_d     = score_q;
        streak_d    = streak_q;
        strum_hit   = bus.strum && (zone != 5'd0) && !judged_q && (bus.frets == zone);
        overstrum   = bus.strum && !strum_hit;
        // A same-cycle hit already consumed the departing row
        note_missed = bus.beat && (zone != 5'd0) && !judged_q && !strum_hit;
        hit_d       = strum_hit;
        miss_d      = overstrum || note_missed;
        score_sum   = {1'b0, score_q} + (17'(mult_w) * 17'd10);

        if (bus.beat) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                row_d[i] = row_q[i + 1];
            end
            row_d[DEPTH-1] = bus.note_in;
        end

        // The incoming zone row is always fresh, even if the old one was hit
        if (bus.beat)      judged_d = 1'b0;
        else if (strum_hit) judged_d = 1'b1;

        if (strum_hit) begin
            streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
            score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end else if (miss_d) begin
            streak_d = '0;
        end
    end

    // State registers; reset wins over any beat/strum in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q    <= '{default: '0};
            judged_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= '0;
            streak_q <= '0;
        end else begin
            row_q    <= row_d;
            judged_q <= judged_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            score_q  <= score_d;
            streak_q <= streak_d;
        end
    end

    // Flatten rows for the display stage: row i at bits [5i+4:5i]
    always_comb begin
        highway_w = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            highway_w[5*i +: 5] = row_q[i];
        end
    end

    assign bus.highway = highway_w;
    assign bus.hit     = hit_q;
    assign bus.miss    = miss_q;
    assign bus.score   = score_q;
    assign bus.streak  = streak_q;
    assign bus.mult    = mult_w;
endmodule

// File: tb/tb_note_highway.sv
// Directed self-checking bench for note_highway.
module tb_note_highway;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    note_highway_if #(.DEPTH(DEPTH)) nh_if ();

    note_highway #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (nh_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Apply inputs for one cycle; outputs are sampled 1ns after the edge
    task automatic drive(input logic r, input logic b, input logic [4:0] n,
                         input logic s, input logic [4:0] f);
        reset         = r;
        nh_if.beat    = b;
        nh_if.note_in = n;
        nh_if.strum   = s;
        nh_if.frets   = f;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        nh_if.beat    = 1'b0;
        nh_if.note_in = 5'd0;
        nh_if.strum   = 1'b0;
        nh_if.frets   = 5'd0;
    endtask

    function automatic int m_mult(input int st);
`ifdef NOTE_HIGHWAY_STREAK_MULT_EN
        if (st >= 30) return 4;
        if (st >= 20) return 3;
        if (st >= 10) return 2;
        return 1;
`else
        return 1;
`endif
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          m_score;
        int          m_streak;
        int          iters;
        logic        bad;
        logic [79:0] all_ones;

        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        nh_if.beat = 1'b0; nh_if.note_in = '0; nh_if.strum = 1'b0; nh_if.frets = '0;
        @(negedge clk);

        // Reset state
        drive(1, 0, 0, 0, 0);
        check("rst_highway", nh_if.highway, 0);
        check("rst_hit", nh_if.hit, 0);
        check("rst_miss", nh_if.miss, 0);
        check("rst_score", nh_if.score, 0);
        check("rst_streak", nh_if.streak, 0);
        check("rst_mult", nh_if.mult, 1);

        // 16 beats of lane 0 fill the highway with no judging events
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 5'b00001, 0, 0);
            if (nh_if.hit || nh_if.miss) bad = 1'b1;
        end
        check("fill_no_events", bad, 0);
        check("fill_row0", nh_if.highway[4:0], 5'b00001);
        all_ones = {16{5'b00001}};
        check("fill_highway", nh_if.highway, all_ones);
        drive(0, 1, 5'b00000, 0, 0);
        check("missed_note_miss", nh_if.miss, 1);
        check("missed_note_hit", nh_if.hit, 0);
        check("missed_note_streak", nh_if.streak, 0);
        drive(0, 0, 0, 0, 0);
        check("miss_one_cycle", nh_if.miss, 0);

        // Correct strum then a second strum on the judged zone
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 5'b00100, 0, 0);
        for (int i = 0; i < DEPTH - 1; i++) drive(0, 1, 0, 0, 0);
        check("zone_loaded", nh_if.highway[4:0], 5'b00100);
        drive(0, 0, 0, 1, 5'b00100);
        check("hit_pulse", nh_if.hit, 1);
        check("hit_nomiss", nh_if.miss, 0);
        check("hit_score", nh_if.score, 10);
        check("hit_streak", nh_if.streak, 1);
        drive(0, 0, 0, 1, 5'b00100);
        check("rejudge_miss", nh_if.miss, 1);
        check("rejudge_hit", nh_if.hit, 0);
        check("rejudge_streak", nh_if.streak, 0);
        check("rejudge_score", nh_if.score, 10);

        // Beat and strum in the same cycle, then same-cycle overstrum + missed note
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 5'b10000, 0, 0);
        drive(0, 1, 5'b00010, 0, 0);
        for (int i = 0; i < DEPTH - 2; i++) drive(0, 1, 0, 0, 0);
        check("zone_10000", nh_if.highway[9:0], {5'b00010, 5'b10000});
        drive(0, 1, 0, 1, 5'b10000);
        check("same_cycle_hit", nh_if.hit, 1);
        check("same_cycle_nomiss", nh_if.miss, 0);
        check("same_cycle_newzone", nh_if.highway[4:0], 5'b00010);
        check("same_cycle_score", nh_if.score, 10);
        drive(0, 1, 0, 1, 5'b00001);
        check("double_miss_pulse", nh_if.miss, 1);
        check("double_miss_nohit", nh_if.hit, 0);
        check("double_miss_streak", nh_if.streak, 0);
        drive(0, 0, 0, 0, 0);
        check("double_miss_width", nh_if.miss, 0);

        // Fret mismatch and strum on an empty zone
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 5'b01000, 0, 0);
        for (int i = 0; i < DEPTH - 1; i++) drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 5'b01010);
        check("mismatch_miss", nh_if.miss, 1);
        check("mismatch_score", nh_if.score, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 5'b00001);
        check("empty_zone_miss", nh_if.miss, 1);
        check("empty_zone_hit", nh_if.hit, 0);

        // 12 consecutive same-cycle hits
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 1, 5'b00001, 0, 0);
        m_score = 0;
        m_streak = 0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            m_score  = m_score + 10 * m_mult(m_streak);
            m_streak = m_streak + 1;
            drive(0, 1, 5'b00001, 1, 5'b00001);
            if (!nh_if.hit || nh_if.miss) bad = 1'b1;
        end
        check("run12_all_hits", bad, 0);
        check("run12_streak", nh_if.streak, 12);
`ifdef NOTE_HIGHWAY_STREAK_MULT_EN
        check("run12_score", nh_if.score, 140);
        check("run12_mult", nh_if.mult, 2);
`else
        check("run12_score", nh_if.score, 120);
        check("run12_mult", nh_if.mult, 1);
`endif

        // Keep hitting until the score saturates
        iters = 0;
        bad = 1'b0;
        while (m_score != 16'hFFFF && iters < 20000) begin
            m_score  = m_score + 10 * m_mult(m_streak);
            if (m_score > 16'hFFFF) m_score = 16'hFFFF;
            if (m_streak < 255) m_streak = m_streak + 1;
            drive(0, 1, 5'b00001, 1, 5'b00001);
            if (!nh_if.hit || nh_if.miss) bad = 1'b1;
            iters++;
        end
        check("sat_all_hits", bad, 0);
        check("sat_score", nh_if.score, 16'hFFFF);
        check("sat_streak", nh_if.streak, 255);
        check("sat_mult", nh_if.mult, m_mult(255));
        drive(0, 1, 5'b00001, 1, 5'b00001);
        check("sat_score_hold", nh_if.score, 16'hFFFF);

        // Reset together with strum: everything cleared, no pulse
        drive(1, 1, 5'b00001, 1, 5'b00001);
        check("rst_strum_hit", nh_if.hit, 0);
        check("rst_strum_miss", nh_if.miss, 0);
        check("rst_strum_score", nh_if.score, 0);
        check("rst_strum_streak", nh_if.streak, 0);
        check("rst_strum_highway", nh_if.highway, 0);
        check("rst_strum_mult", nh_if.mult, 1);
        drive(0, 1, 0, 0, 0);
        check("post_rst_beat_miss", nh_if.miss, 0);
        check("post_rst_beat_hit", nh_if.hit, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
